hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline sequencing controller for the 5-stage integer core. Sits beside the forwarding datapath and decides each cycle whether the pipeline advances, inserts a load-use or RAW bubble, flushes on a taken branch, or freezes entirely while the external SRAM completes a MEM-stage access. It also drives the registered forwarding-select codes consumed by the EXE-stage operand muxes, and keeps saturating stall counters for performance measurement.

## Interface
Parameters:
- CNT_W, 16, width of each saturating performance counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- forward_en  in  1  1 = forwarding mode, 0 = stall-only mode.
- id_src1, id_src2  in  5 each  source registers of the instruction in ID.
- id_two_src  in  1  ID instruction reads id_src2 as a register (store, R-type, BNE).
- exe_dest, exe_wb_en, exe_mem_read  in  5/1/1  destination, write-enable and load flag of the instruction in EXE.
- mem_dest, mem_wb_en  in  5/1  destination and write-enable of the instruction in MEM.
- br_taken  in  1  branch or jump in EXE resolved taken.
- mem_access  in  1  MEM-stage instruction is a load or store.
- sram_ready  in  1  one-cycle pulse from the SRAM controller when the access completes.
- sram_req  out  1  one-cycle access start pulse to the SRAM controller.
- freeze_all  out  1  hold every pipeline register and the PC.
- pc_freeze, if_id_freeze  out  1 each  hold the PC and the IF/ID register.
- if_id_flush, id_exe_flush  out  1 each  load a bubble (all control bits 0).
- fwd_sel1, fwd_sel2  out  2 each  registered EXE operand select: 00 register file, 01 MEM-stage ALU result, 10 WB-stage value.
- stall_cycles, mem_wait_cycles  out  CNT_W each  saturating counters.

## Operation
- Register 0 never creates a hazard and is never forwarded.
- hz_exe: exe_wb_en, and exe_dest equals id_src1, or equals id_src2 while id_two_src is set. hz_mem is the same test against mem_dest and mem_wb_en.
- Hazard stall condition:
  - With forward_en = 1: hazard_stall = exe_mem_read & hz_exe.
  - With forward_en = 0: hazard_stall = hz_exe | hz_mem.
- FSM states: RUN and MEM_WAIT.
  - In RUN, mem_access drives sram_req = 1 and freeze_all = 1, and the next state is MEM_WAIT.
  - In MEM_WAIT, freeze_all = !sram_ready. When sram_ready arrives, the next state is RUN. That cycle the pipeline advances and MEM/WB captures the SRAM data.
  - sram_req is never asserted in MEM_WAIT.
- Per-cycle priority, highest first:
  1. freeze_all. All other control outputs are 0. fwd_sel and the FSM-unrelated state hold.
  2. br_taken. if_id_flush = id_exe_flush = 1 and there is no stall. hazard_stall is ignored because the ID instruction is squashed.
  3. hazard_stall. pc_freeze = if_id_freeze = 1 and id_exe_flush = 1.
  4. Otherwise the pipeline advances normally.
- fwd_sel register update:
  - Priority 1: hold.
  - Priority 2 or 3: load 00.
  - Priority 4: load the computed selects. For each source, the code is 01 if forward_en & hz_exe for that source, else 10 if forward_en & hz_mem, else 00. The newer instruction (EXE) wins.
  - A src2 code is only non-zero when id_two_src is set.
- stall_cycles increments in cycles at priority 3. mem_wait_cycles increments in cycles with freeze_all = 1. Both saturate at all-ones.

## Timing
- Reset puts the FSM in RUN and sets fwd_sel1 = fwd_sel2 = 00 and both counters to 0.
- Combinational outputs (freeze_all, pc_freeze, if_id_freeze, both flushes, sram_req) are 0 during reset and in the first cycle after reset unless the inputs demand otherwise.
- All stall, flush and freeze outputs are combinational from the inputs and the current state, valid in the same cycle.
- fwd_sel becomes valid one cycle after the ID-stage decision, aligned with the instruction entering EXE.
- Load-use in forwarding mode costs exactly 1 bubble. The next cycle the load is in MEM, hz_mem matches, and fwd_sel becomes 10.
- An SRAM access with sram_ready arriving N cycles after sram_req freezes for N cycles: the request cycle plus N-1 waits. The ready cycle itself is not frozen.
- If sram_ready and br_taken occur in the same cycle, the branch flush applies in that cycle.
- rst asserted in MEM_WAIT returns the FSM to RUN next cycle. Any late sram_ready pulse is then ignored.

## Test plan
- Load-use: EXE is a load with exe_dest = 5, ID has src1 = 5, forward_en = 1. Required: one cycle with pc_freeze = if_id_freeze = id_exe_flush = 1, then advance, with fwd_sel1 = 10 the following cycle.
- ALU RAW: exe_dest = 3 (not a load), mem_dest = 3, id_src2 = 3, id_two_src = 1, forward_en = 1. Required: no stall and fwd_sel2 = 01 next cycle. With forward_en = 0, a stall repeats until neither stage matches.
- Register 0 and immediates: exe_dest = 0 matching src1 gives no stall and fwd_sel1 = 00. A src2 match with id_two_src = 0 gives fwd_sel2 = 00.
- Branch over hazard: br_taken = 1 and a load-use hazard in the same cycle. Required: both flushes = 1, pc_freeze = 0, fwd_sel = 00, stall_cycles unchanged.
- SRAM wait: mem_access with sram_ready 3 cycles after sram_req. Required: one sram_req pulse, freeze_all = 1 for 3 cycles, mem_wait_cycles += 3, fwd_sel held throughout.
- Counter saturation and reset: preload via a long stall until stall_cycles = FFFF, then stall once more. Required: the value stays FFFF. Asserting rst in MEM_WAIT gives RUN and zeroed counters and fwd_sel next cycle.

Source files
------------

// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
//
// Pipeline sequencing controller for the 5-stage integer core. Each cycle it
// decides whether the pipeline:
//   - freezes while the external SRAM finishes a MEM-stage access,
//   - flushes on a taken branch,
//   - inserts a bubble for a load-use or RAW hazard, or
//   - advances normally.
// It also registers the forwarding-select codes for the EXE operand muxes and
// keeps saturating stall counters for performance measurement.
//
// Parameters
//   CNT_W            width of each saturating performance counter
//
// Ports
//   clk              core clock, all state updates on the rising edge
//   rst              synchronous active-high reset
//   forward_en       1 = forwarding mode, 0 = stall-only mode
//   id_src1/id_src2  source registers of the ID instruction
//   id_two_src       ID instruction reads id_src2 as a register
//   exe_dest/exe_wb_en/exe_mem_read   EXE instruction destination, wb, load
//   mem_dest/mem_wb_en                MEM instruction destination, wb
//   br_taken         branch/jump in EXE resolved taken
//   mem_access       MEM instruction is a load or store
//   sram_ready       one-cycle completion pulse from the SRAM controller
//   sram_req         one-cycle access start pulse to the SRAM controller
//   freeze_all       hold every pipeline register and the PC
//   pc_freeze        hold the PC
//   if_id_freeze     hold the IF/ID register
//   if_id_flush      load a bubble into IF/ID
//   id_exe_flush     load a bubble into ID/EXE
//   fwd_sel1/2       registered EXE operand select
//                    (00 regfile, 01 MEM ALU result, 10 WB value)
//   stall_cycles     saturating count of hazard-stall cycles
//   mem_wait_cycles  saturating count of freeze_all cycles
// -----------------------------------------------------------------------------
module hazard_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             forward_en,
  input  logic [4:0]       id_src1,
  input  logic [4:0]       id_src2,
  input  logic             id_two_src,
  input  logic [4:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_read,
  input  logic [4:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             br_taken,
  input  logic             mem_access,
  input  logic             sram_ready,
  output logic             sram_req,
  output logic             freeze_all,
  output logic             pc_freeze,
  output logic             if_id_freeze,
  output logic             if_id_flush,
  output logic             id_exe_flush,
  output logic [1:0]       fwd_sel1,
  output logic [1:0]       fwd_sel2,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] mem_wait_cycles
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_r;
  state_t           state_nxt_s;

  logic             hz_exe1_s;
  logic             hz_exe2_s;
  logic             hz_mem1_s;
  logic             hz_mem2_s;
  logic             hz_exe_s;
  logic             hz_mem_s;
  logic             hazard_stall_s;

  logic [1:0]       fwd1_nxt_s;
  logic [1:0]       fwd2_nxt_s;
  logic [1:0]       fwd_sel1_r;
  logic [1:0]       fwd_sel2_r;

  logic             sram_req_s;
  logic             freeze_all_s;
  logic             pc_freeze_s;
  logic             if_id_freeze_s;
  logic             if_id_flush_s;
  logic             id_exe_flush_s;
  logic             do_stall_s;

  logic [CNT_W-1:0] stall_cycles_r;
  logic [CNT_W-1:0] mem_wait_cycles_r;

  // Per-source dependency detection; register 0 never matches, and src2
  // only counts when the ID instruction actually reads it as a register.
  always_comb begin
    hz_exe1_s = exe_wb_en && (exe_dest != 5'd0) && (exe_dest == id_src1);
    hz_exe2_s = exe_wb_en && (exe_dest != 5'd0) && id_two_src &&
                (exe_dest == id_src2);
    hz_mem1_s = mem_wb_en && (mem_dest != 5'd0) && (mem_dest == id_src1);
    hz_mem2_s = mem_wb_en && (mem_dest != 5'd0) && id_two_src &&
                (mem_dest == id_src2);
    hz_exe_s  = hz_exe1_s | hz_exe2_s;
    hz_mem_s  = hz_mem1_s | hz_mem2_s;
  end

  // Stall rule: with forwarding only a load in EXE cannot be bypassed;
  // without forwarding any pending writer in EXE or MEM blocks ID.
  always_comb begin
    if (forward_en) begin
      hazard_stall_s = exe_mem_read & hz_exe_s;
    end else begin
      hazard_stall_s = hz_exe_s | hz_mem_s;
    end
  end

  // Forwarding-select candidates; the EXE producer is newer so it wins.
  always_comb begin
    if (forward_en && hz_exe1_s) begin
      fwd1_nxt_s = SEL_MEM;
    end else if (forward_en && hz_mem1_s) begin
      fwd1_nxt_s = SEL_WB;
    end else begin
      fwd1_nxt_s = SEL_RF;
    end
    if (forward_en && hz_exe2_s) begin
      fwd2_nxt_s = SEL_MEM;
    end else if (forward_en && hz_mem2_s) begin
      fwd2_nxt_s = SEL_WB;
    end else begin
      fwd2_nxt_s = SEL_RF;
    end
  end

  // SRAM handshake decode: the request cycle is frozen, then every wait
  // cycle until the ready pulse; the ready cycle itself lets the pipe move.
  always_comb begin
    sram_req_s   = 1'b0;
    freeze_all_s = 1'b0;
    state_nxt_s  = RUN;
    case (state_r)
      RUN: begin
        sram_req_s   = mem_access;
        freeze_all_s = mem_access;
        if (mem_access) begin
          state_nxt_s = MEM_WAIT;
        end else begin
          state_nxt_s = RUN;
        end
      end
      MEM_WAIT: begin
        sram_req_s   = 1'b0;
        freeze_all_s = !sram_ready;
        if (sram_ready) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = MEM_WAIT;
        end
      end
      default: begin
        sram_req_s   = 1'b0;
        freeze_all_s = 1'b0;
        state_nxt_s  = RUN;
      end
    endcase
  end

  // Priority resolution: freeze > branch flush > hazard bubble > advance.
  // A taken branch squashes the ID instruction, so its hazard is moot.
  always_comb begin
    pc_freeze_s    = 1'b0;
    if_id_freeze_s = 1'b0;
    if_id_flush_s  = 1'b0;
    id_exe_flush_s = 1'b0;
    do_stall_s     = 1'b0;
    if (freeze_all_s) begin
      pc_freeze_s    = 1'b0;
      if_id_freeze_s = 1'b0;
    end else if (br_taken) begin
      if_id_flush_s  = 1'b1;
      id_exe_flush_s = 1'b1;
    end else if (hazard_stall_s) begin
      pc_freeze_s    = 1'b1;
      if_id_freeze_s = 1'b1;
      id_exe_flush_s = 1'b1;
      do_stall_s     = 1'b1;
    end else begin
      do_stall_s     = 1'b0;
    end
  end

  // Memory-access FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Forwarding selects: hold while frozen, clear when the ID instruction
  // becomes a bubble, otherwise follow it into EXE.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_sel1_r <= SEL_RF;
      fwd_sel2_r <= SEL_RF;
    end else if (freeze_all_s) begin
      fwd_sel1_r <= fwd_sel1_r;
      fwd_sel2_r <= fwd_sel2_r;
    end else if (br_taken || hazard_stall_s) begin
      fwd_sel1_r <= SEL_RF;
      fwd_sel2_r <= SEL_RF;
    end else begin
      fwd_sel1_r <= fwd1_nxt_s;
      fwd_sel2_r <= fwd2_nxt_s;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_r    <= '0;
      mem_wait_cycles_r <= '0;
    end else begin
      if (do_stall_s && (stall_cycles_r != CNT_MAX)) begin
        stall_cycles_r <= stall_cycles_r + CNT_ONE;
      end else begin
        stall_cycles_r <= stall_cycles_r;
      end
      if (freeze_all_s && (mem_wait_cycles_r != CNT_MAX)) begin
        mem_wait_cycles_r <= mem_wait_cycles_r + CNT_ONE;
      end else begin
        mem_wait_cycles_r <= mem_wait_cycles_r;
      end
    end
  end

  assign sram_req        = sram_req_s;
  assign freeze_all      = freeze_all_s;
  assign pc_freeze       = pc_freeze_s;
  assign if_id_freeze    = if_id_freeze_s;
  assign if_id_flush     = if_id_flush_s;
  assign id_exe_flush    = id_exe_flush_s;
  assign fwd_sel1        = fwd_sel1_r;
  assign fwd_sel2        = fwd_sel2_r;
  assign stall_cycles    = stall_cycles_r;
  assign mem_wait_cycles = mem_wait_cycles_r;

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        forward_en;
  logic [4:0]  id_src1, id_src2;
  logic        id_two_src;
  logic [4:0]  exe_dest;
  logic        exe_wb_en, exe_mem_read;
  logic [4:0]  mem_dest;
  logic        mem_wb_en;
  logic        br_taken, mem_access, sram_ready;
  logic        sram_req, freeze_all, pc_freeze, if_id_freeze;
  logic        if_id_flush, id_exe_flush;
  logic [1:0]  fwd_sel1, fwd_sel2;
  logic [15:0] stall_cycles, mem_wait_cycles;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_controller #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .forward_en(forward_en),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .br_taken(br_taken),
    .mem_access(mem_access), .sram_ready(sram_ready), .sram_req(sram_req),
    .freeze_all(freeze_all), .pc_freeze(pc_freeze), .if_id_freeze(if_id_freeze),
    .if_id_flush(if_id_flush), .id_exe_flush(id_exe_flush),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .stall_cycles(stall_cycles), .mem_wait_cycles(mem_wait_cycles)
  );

  // ctrl = {pc_freeze, if_id_freeze, if_id_flush, id_exe_flush}
  typedef struct packed {
    logic       fe;
    logic [4:0] s1;
    logic [4:0] s2;
    logic       two;
    logic [4:0] ed;
    logic       ewb;
    logic       emr;
    logic [4:0] md;
    logic       mwb;
    logic       br;
    logic [3:0] ctrl;
    logic [1:0] fs1;
    logic [1:0] fs2;
    logic       sinc;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    forward_en = 1'b1; id_src1 = 5'd0; id_src2 = 5'd0; id_two_src = 1'b0;
    exe_dest = 5'd0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
    mem_dest = 5'd0; mem_wb_en = 1'b0; br_taken = 1'b0;
    mem_access = 1'b0; sram_ready = 1'b0;
  endtask

  task automatic load_use(input logic [4:0] r);
    exe_dest = r; exe_wb_en = 1'b1; exe_mem_read = 1'b1; id_src1 = r;
  endtask

  // Called just after a rising edge; occupies exactly one clock cycle.
  task automatic apply_vec(input int idx, input vec_t v);
    logic [15:0] s0;
    forward_en = v.fe; id_src1 = v.s1; id_src2 = v.s2; id_two_src = v.two;
    exe_dest = v.ed; exe_wb_en = v.ewb; exe_mem_read = v.emr;
    mem_dest = v.md; mem_wb_en = v.mwb; br_taken = v.br;
    mem_access = 1'b0; sram_ready = 1'b0;
    s0 = stall_cycles;
    @(negedge clk);
    chk($sformatf("v%0d_ctrl", idx),
        {28'd0, pc_freeze, if_id_freeze, if_id_flush, id_exe_flush}, {28'd0, v.ctrl});
    chk($sformatf("v%0d_freeze", idx), {31'd0, freeze_all}, 32'd0);
    @(posedge clk); #1;
    chk($sformatf("v%0d_fwd", idx), {28'd0, fwd_sel1, fwd_sel2}, {28'd0, v.fs1, v.fs2});
    chk($sformatf("v%0d_stall_cnt", idx), {16'd0, stall_cycles},
        {16'd0, s0 + {15'd0, v.sinc}});
  endtask

  initial begin
    logic [15:0] mw0, st0;
    int reqs;
    //           fe s1    s2    two ed    ewb  emr  md    mwb  br   ctrl     fs1    fs2    sinc
    vecs[0]  = '{1'b1, 5'd1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 4'b0000, 2'b00, 2'b00, 1'b0};
    vecs[1]  = '{1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 4'b1101, 2'b00, 2'b00, 1'b1};
    vecs[2]  = '{1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 4'b0000, 2'b10, 2'b00, 1'b0};
    vecs[3]  = '{1'b1, 5'd1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 4'b0000, 2'b00, 2'b01, 1'b0};
    vecs[4]  = '{1'b0, 5'd1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 4'b1101, 2'b00, 2'b00, 1'b1};
    vecs[5]  = '{1'b0, 5'd1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 4'b1101, 2'b00, 2'b00, 1'b1};
    vecs[6]  = '{1'b0, 5'd1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 4'b0000, 2'b00, 2'b00, 1'b0};
    vecs[7]  = '{1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 4'b0000, 2'b00, 2'b00, 1'b0};
    vecs[8]  = '{1'b1, 5'd9, 5'd4, 1'b0, 5'd4, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 4'b0000, 2'b00, 2'b00, 1'b0};
    vecs[9]  = '{1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 4'b0011, 2'b00, 2'b00, 1'b0};
    vecs[10] = '{1'b1, 5'd6, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 4'b0000, 2'b01, 2'b10, 1'b0};
    vecs[11] = '{1'b1, 5'd9, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 4'b0000, 2'b01, 2'b01, 1'b0};
    vecs[12] = '{1'b1, 5'd5, 5'd5, 1'b1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 4'b0000, 2'b00, 2'b00, 1'b0};
    vecs[13] = '{1'b0, 5'd2, 5'd6, 1'b1, 5'd1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 4'b1101, 2'b00, 2'b00, 1'b1};

    // Reset state
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ctrl", {26'd0, sram_req, freeze_all, pc_freeze, if_id_freeze,
                     if_id_flush, id_exe_flush}, 32'd0);
    chk("rst_fwd", {28'd0, fwd_sel1, fwd_sel2}, 32'd0);
    chk("rst_cnt", {stall_cycles, mem_wait_cycles}, 32'd0);
    @(posedge clk); #1;

    // Table-driven single-cycle decisions
    for (int i = 0; i < 14; i++) apply_vec(i, vecs[i]);

    // SRAM wait: ready 3 cycles after request, fwd_sel held throughout
    apply_vec(100, vecs[10]);
    clear_inputs();
    mw0 = mem_wait_cycles; st0 = stall_cycles; reqs = 0;
    mem_access = 1'b1;
    for (int c = 0; c < 4; c++) begin
      br_taken   = (c == 1 || c == 3);
      sram_ready = (c == 3);
      if (c >= 2) load_use(5'd5);
      @(negedge clk);
      if (sram_req) reqs++;
      chk($sformatf("sram_c%0d_freeze", c), {31'd0, freeze_all}, {31'd0, (c != 3)});
      chk($sformatf("sram_c%0d_ctl", c), {28'd0, pc_freeze, if_id_freeze, if_id_flush, id_exe_flush},
          (c == 3) ? 32'h3 : 32'h0);
      @(posedge clk); #1;
      chk($sformatf("sram_c%0d_fwd", c), {28'd0, fwd_sel1, fwd_sel2},
          (c == 3) ? 32'h0 : 32'h6);
    end
    chk("sram_req_pulses", reqs, 32'd1);
    chk("sram_wait_cnt", {16'd0, mem_wait_cycles}, {16'd0, mw0 + 16'd3});
    chk("sram_stall_cnt", {16'd0, stall_cycles}, {16'd0, st0});
    clear_inputs();
    @(negedge clk);
    chk("sram_back_run", {31'd0, freeze_all}, 32'd0);
    @(posedge clk); #1;

    // Counter saturation via a long load-use stall
    load_use(5'd5);
    for (int i = 0; i < 70000 && stall_cycles != 16'hFFFF; i++) begin
      @(posedge clk); #1;
    end
    chk("sat_preload", {16'd0, stall_cycles}, 32'h0000FFFF);
    @(negedge clk);
    chk("sat_stalling", {31'd0, pc_freeze}, 32'd1);
    @(posedge clk); #1;
    chk("sat_hold", {16'd0, stall_cycles}, 32'h0000FFFF);

    // Reset while in MEM_WAIT, then a late ready pulse must be ignored
    apply_vec(101, vecs[10]);
    clear_inputs();
    mem_access = 1'b1;
    @(posedge clk); #1;
    mem_access = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_cnt", {stall_cycles, mem_wait_cycles}, 32'd0);
    chk("mrst_fwd", {28'd0, fwd_sel1, fwd_sel2}, 32'd0);
    @(negedge clk);
    chk("mrst_run", {30'd0, freeze_all, sram_req}, 32'd0);
    @(posedge clk); #1;
    sram_ready = 1'b1;
    @(negedge clk);
    chk("late_ready", {30'd0, freeze_all, sram_req}, 32'd0);
    @(posedge clk); #1;
    sram_ready = 1'b0;
    mem_access = 1'b1;
    @(negedge clk);
    chk("new_req", {30'd0, freeze_all, sram_req}, 32'd3);
    @(posedge clk); #1;
    chk("new_req_cnt", {16'd0, mem_wait_cycles}, 32'd1);
    clear_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
